// File: rtl/alu_mul_seq.sv
// Sequential unsigned 32-bit multiplier that computes the product by repeated addition.
// All arithmetic and comparison is delegated to an external combinational ALU.
module alu_mul_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] mcand,
  input  logic [31:0] mplier,
  output logic        busy,
  output logic        done,
  output logic [31:0] product,
  output logic [31:0] ALUop1,
  output logic [31:0] ALUop2,
  output logic [2:0]  ALUcntrl,
  input  logic [31:0] ALUout,
  input  logic        EQ
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_EQ   = 3'b101;
  localparam logic [2:0] OP_IDLE = 3'b111;

  typedef enum logic [2:0] {IDLE, CHECK, ACC, DEC, DONE} state_t;

  typedef struct packed {
    logic [31:0] a;    // multiplicand
    logic [31:0] n;    // remaining iterations
    logic [31:0] acc;  // running sum
  } opnd_t;

  state_t state, nxt;
  opnd_t  r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // Datapath registers only ever load operands or the ALU result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r       <= '0;
      product <= '0;
    end else begin
      unique case (state)
        IDLE:  if (start) begin
                 r.a   <= mcand;
                 r.n   <= mplier;
                 r.acc <= '0;
               end
        ACC:   r.acc   <= ALUout;
        DEC:   r.n     <= ALUout;
        DONE:  product <= r.acc;
        default: ;
      endcase
    end
  end

  always_comb begin
    nxt      = state;
    ALUop1   = '0;
    ALUop2   = '0;
    ALUcntrl = OP_IDLE;
    busy     = 1'b1;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) nxt = CHECK;
      end
      CHECK: begin
        ALUop1   = r.n;
        ALUcntrl = OP_EQ;
        nxt      = EQ ? DONE : ACC;
      end
      ACC: begin
        ALUop1   = r.acc;
        ALUop2   = r.a;
        ALUcntrl = OP_ADD;
        nxt      = DEC;
      end
      DEC: begin
        ALUop1   = r.n;
        ALUop2   = 32'd1;
        ALUcntrl = OP_SUB;
        nxt      = CHECK;
      end
      DONE: begin
        done = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

endmodule
